anahtar_genisletme: RTL and testbench
=====================================

// Module: anahtar_genisletme
// PURPOSE
//  Iterative AES-128 key-expansion engine. Loads a 128-bit cipher key, emits round keys 0..10 one at a time.
//  Sits upstream of the round/final-round stages; key 10 feeds the final round's AddRoundKey input.
//  Valid/ready output handshake: the consumer paces expansion, one key per accepted transfer.
// PARAMETERS
//  TUR_SAYISI   10   number of rounds; round keys 0..TUR_SAYISI emitted (only 10 supported, AES-128)
//  ANAHTAR_W    128  key/round-key width in bits (fixed 128)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous, active-high reset
//  baslat       in   1    start pulse; sampled only in BOSTA
//  anahtar      in   128  cipher key, sampled when baslat accepted; word0 = [127:96]
//  tur_anahtari out  128  current round key
//  tur_no       out  4    index of tur_anahtari (0..10)
//  tur_gecerli  out  1    tur_anahtari/tur_no valid
//  tur_hazir    in   1    consumer ready; transfer when tur_gecerli & tur_hazir
//  bitti        out  1    one-cycle pulse after key 10 transferred
//  mesgul       out  1    high in URET and BITTI
//  oku_adr      in   4    stored-key read index (KEY_STORE_EN only)
//  oku_veri     out  128  stored round key (KEY_STORE_EN only)
// BEHAVIOUR
//  Reset: state=BOSTA; tur_anahtari=0, tur_no=0, tur_gecerli=0, bitti=0, mesgul=0, oku_veri=0.
//  FSM: BOSTA -(baslat)-> URET -(transfer with tur_no==10)-> BITTI -(always)-> BOSTA.
//  BOSTA: baslat at edge t loads anahtar; key 0 valid at t+1 (tur_no=0, tur_gecerli=1).
//  URET: tur_gecerli=1 throughout; tur_anahtari/tur_no held stable while !tur_hazir.
//  Transfer with tur_no<10: next cycle tur_anahtari = expand(current, rcon[tur_no]), tur_no+1.
//  With tur_hazir held high: key r presented at t+1+r, key 10 at t+11, bitti=1 at t+12 only.
//  expand: tmp = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^tmp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//  RotWord {a,b,c,d}->{b,c,d,a}; SubWord = forward AES S-box per byte; all XOR, no carries.
//  rcon[0..9] = 01,02,04,08,10,20,40,80,1B,36 (indexed by tur_no of current key).
//  baslat ignored outside BOSTA (no restart mid-expansion); baslat during BITTI ignored.
//  tur_hazir with tur_gecerli=0 has no effect. tur_gecerli drops to 0 in BITTI.
//  rst mid-expansion: returns to BOSTA next edge, outputs to reset values, stored keys cleared.
//  Expansion path is one combinational stage (S-box + XOR chain) between registers.
// CONFIGURATION
//  KEY_STORE_EN defined: 11x128 register file; each transferred key written at index tur_no.
//   oku_veri = store[oku_adr] combinationally; oku_adr>10 returns 0. Contents persist until next
//   accepted baslat (entries then overwritten as keys are produced) or rst (cleared to 0).
//   Used by decryption path to replay keys in reverse without re-expansion.
//  KEY_STORE_EN undefined: no storage; oku_veri tied to 0, oku_adr ignored.
// STRUCTURE
//  Shared package: AES_SBOX table (256x8), RCON table (10x8), FSM state encoding
//   (BOSTA, URET, BITTI), constants TUR_SAYISI=10, KELIME_W=32.
//  Sub-module: anahtar_sbox_kelime - 32-bit word -> 4 parallel S-box lookups, combinational.
//  Top: FSM, round counter, key register, rcon select, optional key store.
// TESTING
//  Key 2b7e151628aed2a6abf7158809cf4f3c, baslat, tur_hazir=1 -> key0 = input at t+1;
//   key1 = a0fafe1788542cb123a339392a6c7605 at t+2; key10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+11; bitti at t+12.
//  Same key, tur_hazir toggled 1/0 per cycle -> identical key sequence, each held stable while low; bitti after 11th transfer.
//  Key all-zero -> key1 = 62636363626363636263636362636363; key10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  rst asserted while tur_no=5 -> next cycle tur_gecerli=0, tur_no=0, mesgul=0; new baslat restarts from key0.
//  baslat pulsed during URET (tur_no=3) -> ignored; sequence continues to key 10 unchanged.
//  KEY_STORE_EN: after full run with FIPS key, oku_adr=10 -> d014f9a8...0ca6; oku_adr=15 -> 0; undefined -> oku_veri=0.

Source files
------------

// File: rtl/anahtar_genisletme_pkg.sv
// Shared definitions for the AES-128 key-expansion engine: S-box, round constants, FSM states.
// Optional round-key store in the top is enabled with `define KEY_STORE_EN.
package anahtar_genisletme_pkg;

    localparam int unsigned TUR_SAYISI = 10;
    localparam int unsigned KELIME_W   = 32;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        URET  = 2'd1,
        BITTI = 2'd2
    } durum_t;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox_bayt(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

    // Out-of-range indices (only reachable on the last key, which is never expanded) give 0.
    function automatic logic [7:0] rcon_sec(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (i == 4'(k)) r = RCON[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/anahtar_genisletme_sbox_kelime.sv
// Combinational SubWord: four parallel forward AES S-box lookups on a 32-bit word.
module anahtar_sbox_kelime
    import anahtar_genisletme_pkg::*;
(
    input  logic [KELIME_W-1:0] kelime,
    output logic [KELIME_W-1:0] sonuc_c
);

    always_comb begin
        sonuc_c = '0;
        for (int i = 0; i < 4; i++) begin
            sonuc_c[i*8 +: 8] = sbox_bayt(kelime[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/anahtar_genisletme.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over a valid/ready handshake.
// `define KEY_STORE_EN adds an 11-entry round-key store readable through oku_adr/oku_veri.
module anahtar_genisletme
    import anahtar_genisletme_pkg::*;
#(
    parameter int unsigned TUR_SAYISI = 10,
    parameter int unsigned ANAHTAR_W  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baslat,
    input  logic [ANAHTAR_W-1:0] anahtar,
    output logic [ANAHTAR_W-1:0] tur_anahtari,
    output logic [3:0]           tur_no,
    output logic                 tur_gecerli,
    input  logic                 tur_hazir,
    output logic                 bitti,
    output logic                 mesgul,
    input  logic [3:0]           oku_adr,
    output logic [ANAHTAR_W-1:0] oku_veri
);

    localparam logic [3:0] SON_TUR = 4'(TUR_SAYISI);

    durum_t               durum, durum_n;
    logic [ANAHTAR_W-1:0] anahtar_n;
    logic [3:0]           no_n;
    logic                 gecerli_n, bitti_n, mesgul_n;
    logic                 aktarim;

    logic [KELIME_W-1:0]  w0, w1, w2, w3, rot, sub, tmp;
    logic [KELIME_W-1:0]  y0, y1, y2, y3;

    assign aktarim = tur_gecerli & tur_hazir;

    // One-stage expansion of the presented key into the next round key.
    assign {w0, w1, w2, w3} = tur_anahtari;
    assign rot = {w3[23:0], w3[31:24]};

    anahtar_sbox_kelime u_sbox (
        .kelime  (rot),
        .sonuc_c (sub)
    );

    assign tmp = sub ^ {rcon_sec(tur_no), 24'h0};
    assign y0  = w0 ^ tmp;
    assign y1  = w1 ^ y0;
    assign y2  = w2 ^ y1;
    assign y3  = w3 ^ y2;

    always_ff @(posedge clk) begin
        if (rst) begin
            durum        <= BOSTA;
            tur_anahtari <= '0;
            tur_no       <= '0;
            tur_gecerli  <= 1'b0;
            bitti        <= 1'b0;
            mesgul       <= 1'b0;
        end else begin
            durum        <= durum_n;
            tur_anahtari <= anahtar_n;
            tur_no       <= no_n;
            tur_gecerli  <= gecerli_n;
            bitti        <= bitti_n;
            mesgul       <= mesgul_n;
        end
    end

    always_comb begin
        durum_n   = durum;
        anahtar_n = tur_anahtari;
        no_n      = tur_no;
        gecerli_n = tur_gecerli;
        bitti_n   = 1'b0;
        mesgul_n  = mesgul;
        case (durum)
            BOSTA: begin
                gecerli_n = 1'b0;
                mesgul_n  = 1'b0;
                if (baslat) begin
                    durum_n   = URET;
                    anahtar_n = anahtar;
                    no_n      = '0;
                    gecerli_n = 1'b1;
                    mesgul_n  = 1'b1;
                end
            end
            URET: begin
                gecerli_n = 1'b1;
                mesgul_n  = 1'b1;
                if (aktarim) begin
                    if (tur_no == SON_TUR) begin
                        durum_n   = BITTI;
                        gecerli_n = 1'b0;
                        bitti_n   = 1'b1;
                    end else begin
                        anahtar_n = {y0, y1, y2, y3};
                        no_n      = tur_no + 4'd1;
                    end
                end
            end
            BITTI: begin
                durum_n   = BOSTA;
                gecerli_n = 1'b0;
                mesgul_n  = 1'b0;
            end
            default: begin
                durum_n   = BOSTA;
                gecerli_n = 1'b0;
                mesgul_n  = 1'b0;
            end
        endcase
    end

`ifdef KEY_STORE_EN
    logic [ANAHTAR_W-1:0] depo [TUR_SAYISI+1];

    // Each transferred key lands at its round index for later reverse-order replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= int'(TUR_SAYISI); i++) begin
                depo[i] <= '0;
            end
        end else if (durum == URET && aktarim) begin
            depo[tur_no] <= tur_anahtari;
        end
    end

    assign oku_veri = (oku_adr <= SON_TUR) ? depo[oku_adr] : '0;
`else
    logic unused_oku_adr;
    assign unused_oku_adr = ^oku_adr;
    assign oku_veri       = '0;
`endif

endmodule

// File: tb/tb_anahtar_genisletme.sv
// Directed bench for anahtar_genisletme using FIPS-197 and all-zero key expansions.
module tb_anahtar_genisletme;

    logic         clk;
    logic         rst;
    logic         baslat;
    logic [127:0] anahtar;
    logic [127:0] tur_anahtari;
    logic [3:0]   tur_no;
    logic         tur_gecerli;
    logic         tur_hazir;
    logic         bitti;
    logic         mesgul;
    logic [3:0]   oku_adr;
    logic [127:0] oku_veri;

    int checks   = 0;
    int failures = 0;
    int idx;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    anahtar_genisletme dut (
        .clk          (clk),
        .rst          (rst),
        .baslat       (baslat),
        .anahtar      (anahtar),
        .tur_anahtari (tur_anahtari),
        .tur_no       (tur_no),
        .tur_gecerli  (tur_gecerli),
        .tur_hazir    (tur_hazir),
        .bitti        (bitti),
        .mesgul       (mesgul),
        .oku_adr      (oku_adr),
        .oku_veri     (oku_veri)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        baslat    = 1'b0;
        anahtar   = '0;
        tur_hazir = 1'b0;
        oku_adr   = 4'd0;
        tick();
        tick();
        chk("rst_gecerli", 128'(tur_gecerli), 128'd0);
        chk("rst_no",      128'(tur_no),      128'd0);
        chk("rst_key",     tur_anahtari,      128'd0);
        chk("rst_bitti",   128'(bitti),       128'd0);
        chk("rst_mesgul",  128'(mesgul),      128'd0);
        chk("rst_oku",     oku_veri,          128'd0);
        rst = 1'b0;
        tick();

        // Full FIPS-197 run with the consumer always ready.
        anahtar   = FIPS_KEY;
        baslat    = 1'b1;
        tur_hazir = 1'b1;
        tick();
        baslat = 1'b0;
        chk("f_key0",    tur_anahtari,       fips[0]);
        chk("f_no0",     128'(tur_no),       128'd0);
        chk("f_gec0",    128'(tur_gecerli),  128'd1);
        chk("f_mesgul0", 128'(mesgul),       128'd1);
        for (int r = 1; r <= 10; r++) begin
            tick();
            chk($sformatf("f_key%0d", r),   tur_anahtari, fips[r]);
            chk($sformatf("f_no%0d", r),    128'(tur_no), 128'(r));
            chk($sformatf("f_bitti%0d", r), 128'(bitti),  128'd0);
        end
        tick();
        chk("f_bitti",      128'(bitti),       128'd1);
        chk("f_gec_bitti",  128'(tur_gecerli), 128'd0);
        chk("f_mes_bitti",  128'(mesgul),      128'd1);
        tick();
        chk("f_bitti_once", 128'(bitti),       128'd0);
        chk("f_mes_idle",   128'(mesgul),      128'd0);

        // Consumer ready toggles every cycle: keys held while not ready.
        anahtar = FIPS_KEY;
        baslat  = 1'b1;
        tick();
        baslat = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx <= 10; c++) begin
            tur_hazir = (c % 2 == 0);
            chk($sformatf("t_key%0d_c%0d", idx, c), tur_anahtari, fips[idx]);
            chk($sformatf("t_no%0d_c%0d", idx, c),  128'(tur_no), 128'(idx));
            tick();
            if (tur_hazir) idx++;
        end
        chk("t_bitti", 128'(bitti), 128'd1);
        tick();
        tur_hazir = 1'b1;

        // All-zero key.
        anahtar = '0;
        baslat  = 1'b1;
        tick();
        baslat = 1'b0;
        chk("z_key0", tur_anahtari, 128'd0);
        tick();
        chk("z_key1", tur_anahtari, 128'h62636363626363636263636362636363);
        for (int r = 2; r <= 10; r++) tick();
        chk("z_key10", tur_anahtari, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("z_no10",  128'(tur_no), 128'd10);
        tick();
        chk("z_bitti", 128'(bitti), 128'd1);
        tick();

        // Reset in the middle of an expansion.
        anahtar = FIPS_KEY;
        baslat  = 1'b1;
        tick();
        baslat = 1'b0;
        for (int r = 1; r <= 5; r++) tick();
        chk("r_no5", 128'(tur_no), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_gec",    128'(tur_gecerli), 128'd0);
        chk("r_no",     128'(tur_no),      128'd0);
        chk("r_mesgul", 128'(mesgul),      128'd0);
        chk("r_key",    tur_anahtari,      128'd0);
        oku_adr = 4'd3;
        #1;
        chk("r_oku3",   oku_veri,          128'd0);
        oku_adr = 4'd0;

        // Restart, then a start pulse mid-expansion must be ignored.
        anahtar = FIPS_KEY;
        baslat  = 1'b1;
        tick();
        baslat = 1'b0;
        chk("s_key0", tur_anahtari, fips[0]);
        for (int r = 1; r <= 3; r++) tick();
        chk("s_no3", 128'(tur_no), 128'd3);
        anahtar = '0;
        baslat  = 1'b1;
        tick();
        baslat = 1'b0;
        chk("s_key4", tur_anahtari, fips[4]);
        chk("s_no4",  128'(tur_no), 128'd4);
        for (int r = 5; r <= 10; r++) tick();
        chk("s_key10", tur_anahtari, fips[10]);
        tick();
        chk("s_bitti", 128'(bitti), 128'd1);
        // Start during BITTI is ignored.
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
        chk("b_gec",    128'(tur_gecerli), 128'd0);
        chk("b_mesgul", 128'(mesgul),      128'd0);
        tick();
        chk("b_gec2",   128'(tur_gecerli), 128'd0);
        chk("b_no",     128'(tur_no),      128'd10);

        // Key store readback.
        oku_adr = 4'd10;
        #1;
`ifdef KEY_STORE_EN
        chk("k_oku10", oku_veri, fips[10]);
        oku_adr = 4'd1;
        #1;
        chk("k_oku1",  oku_veri, fips[1]);
`else
        chk("k_oku10", oku_veri, 128'd0);
`endif
        oku_adr = 4'd15;
        #1;
        chk("k_oku15", oku_veri, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
